// File: rtl/rtcl_p3s7_spi_master_if.sv
// Command/result handshake between a host and the PYTHON sensor SPI master.
interface rtcl_p3s7_spi_master_if #(
  parameter int ADDR_BITS = 9,
  parameter int DATA_BITS = 16
);
  logic [ADDR_BITS-1:0] s_addr;
  logic                 s_write;
  logic [DATA_BITS-1:0] s_wdata;
  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_BITS-1:0] m_rdata;
  logic                 m_valid;

  modport master (output s_addr, s_write, s_wdata, s_valid,
                  input  s_ready, m_rdata, m_valid);
  modport slave  (input  s_addr, s_write, s_wdata, s_valid,
                  output s_ready, m_rdata, m_valid);
endinterface

// File: rtl/rtcl_p3s7_spi_master.sv
// SPI mode-0 register master for the PYTHON sensor: one address/write/data frame per command.
// Define RTCL_P3S7_SPI_READBACK_EN to build miso sampling and the m_rdata register.
module rtcl_p3s7_spi_master #(
  parameter int ADDR_BITS = 9,
  parameter int DATA_BITS = 16,
  parameter int CLK_DIV   = 4,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter int CS_GAP    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  rtcl_p3s7_spi_master_if.slave cmd,
  output logic                 busy,
  output logic                 spi_ss_n,
  output logic                 spi_sck,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);
  localparam int F     = ADDR_BITS + 1 + DATA_BITS;
  localparam int CNT_W = 16;
  localparam int BIT_W = $clog2(F + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [F-1:0]       tx;
  logic               is_read;
  logic               ready_r;
  logic               valid_r;

  assign cmd.s_ready = ready_r;
  assign cmd.m_valid = valid_r;

  // tx is pre-shifted so its MSB is always the next bit to drive on mosi
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx       <= '0;
      is_read  <= 1'b0;
      ready_r  <= 1'b0;
      valid_r  <= 1'b0;
      busy     <= 1'b0;
      spi_ss_n <= 1'b1;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (ready_r && cmd.s_valid) begin
            tx       <= {cmd.s_addr, cmd.s_write, cmd.s_wdata & {DATA_BITS{cmd.s_write}}};
            is_read  <= !cmd.s_write;
            state    <= SETUP;
            cnt      <= CNT_W'(CS_SETUP - 1);
            ready_r  <= 1'b0;
            busy     <= 1'b1;
            spi_ss_n <= 1'b0;
          end else begin
            ready_r <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state    <= SHIFT;
            cnt      <= CNT_W'(CLK_DIV - 1);
            bit_cnt  <= BIT_W'(F - 1);
            spi_mosi <= tx[F-1];
            tx       <= tx << 1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!spi_sck) begin
            spi_sck <= 1'b1;
            cnt     <= CNT_W'(CLK_DIV - 1);
          end else if (bit_cnt == '0) begin
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
            state    <= HOLD;
            cnt      <= CNT_W'(CS_HOLD - 1);
          end else begin
            spi_sck  <= 1'b0;
            spi_mosi <= tx[F-1];
            tx       <= tx << 1;
            bit_cnt  <= bit_cnt - 1'b1;
            cnt      <= CNT_W'(CLK_DIV - 1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            spi_ss_n <= 1'b1;
            state    <= GAP;
            cnt      <= CNT_W'(CS_GAP - 1);
            valid_r  <= is_read;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state   <= IDLE;
            busy    <= 1'b0;
            ready_r <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RTCL_P3S7_SPI_READBACK_EN
  logic [DATA_BITS-1:0] rx;
  logic [DATA_BITS-1:0] rdata_r;

  // miso is taken on the edge that raises sck; the low DATA_BITS samples are the reply
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx      <= '0;
      rdata_r <= '0;
    end else begin
      if (state == SHIFT && cnt == '0 && !spi_sck)
        rx <= {rx[DATA_BITS-2:0], spi_miso};
      if (state == HOLD && cnt == '0 && is_read)
        rdata_r <= rx;
    end
  end

  assign cmd.m_rdata = rdata_r;
`else
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign cmd.m_rdata = '0;
`endif
endmodule

// File: doc/rtcl_p3s7_spi_master.md
RTCL_P3S7_SPI_MASTER -- requirements
Module: rtcl_p3s7_spi_master

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 9, register address width.
REQ-002 The block SHALL have parameter DATA_BITS, default 16, register data width.
REQ-003 The block SHALL have parameter CLK_DIV, default 4, SCK half-period in clk cycles (>=1).
REQ-004 The block SHALL have parameters CS_SETUP, CS_HOLD and CS_GAP, defaults 2, 2 and 4, in clk cycles (each >=1).
REQ-005 The block SHALL have port clk, input, 1, the single clock.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port s_addr, input, ADDR_BITS, command register address.
REQ-008 The block SHALL have port s_write, input, 1, 1=write, 0=read.
REQ-009 The block SHALL have port s_wdata, input, DATA_BITS, write data.
REQ-010 The block SHALL have ports s_valid (input, 1) and s_ready (output, 1), the command handshake.
REQ-011 The block SHALL have ports m_rdata (output, DATA_BITS, read result) and m_valid (output, 1, one-cycle result strobe).
REQ-012 The block SHALL have output busy, 1, high whenever state is not IDLE.
REQ-013 The block SHALL have ports spi_ss_n (output), spi_sck (output), spi_mosi (output) and spi_miso (input), all 1 bit, to the PYTHON sensor.

Function
REQ-014 The frame SHALL be F = ADDR_BITS+1+DATA_BITS bits, sent MSB first: address, then the write bit, then data (the data field is 0 for reads).
REQ-015 s_ready SHALL be high only in IDLE; a command SHALL be accepted on a clk edge where s_valid && s_ready.
REQ-016 The FSM SHALL have states IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
REQ-017 On acceptance the FSM SHALL go to SETUP, with spi_ss_n low from the next cycle for CS_SETUP cycles and spi_sck low.
REQ-018 In SHIFT, each bit SHALL take CLK_DIV cycles with sck low, then CLK_DIV cycles with sck high.
REQ-019 In SHIFT, mosi SHALL change only at the start of the low phase.
REQ-020 In SHIFT, miso SHALL be sampled on the cycle in which sck rises.
REQ-021 After F bits the FSM SHALL enter HOLD for CS_HOLD cycles, with sck low and ss_n low.
REQ-022 After HOLD, ss_n SHALL go high and the FSM SHALL enter GAP for CS_GAP cycles, then IDLE.
REQ-023 ss_n SHALL be low for exactly CS_SETUP + 2*CLK_DIV*F + CS_HOLD cycles.
REQ-024 For a read, the last DATA_BITS sampled miso bits SHALL be loaded into m_rdata, and m_valid SHALL pulse for 1 cycle on the first GAP cycle.
REQ-025 m_rdata SHALL hold its value until the next read completes.
REQ-026 For a write, m_valid SHALL NOT assert.
REQ-027 The command inputs SHALL be latched at acceptance; changes to them afterward SHALL have no effect.
REQ-028 With s_valid held high, the next command SHALL be accepted on the first IDLE cycle, giving back-to-back frames separated by at least CS_GAP cycles of ss_n high.
REQ-029 SCK SHALL idle low (mode 0), and mosi SHALL be 0 outside SHIFT.

Reset
REQ-030 Asserting reset SHALL immediately force: state IDLE, spi_ss_n=1, spi_sck=0, spi_mosi=0, m_valid=0, m_rdata=0, busy=0, s_ready=0.
REQ-031 s_ready SHALL rise on the first clk edge after reset is released.
REQ-032 Reset asserted mid-transfer SHALL abort the frame, with no m_valid pulse.

Configuration
REQ-033 With macro RTCL_P3S7_SPI_READBACK_EN defined, miso sampling and the m_rdata register SHALL be built as specified.
REQ-034 With RTCL_P3S7_SPI_READBACK_EN undefined, m_rdata SHALL be constant 0 and spi_miso unused.
REQ-035 With RTCL_P3S7_SPI_READBACK_EN undefined, read frames and the m_valid pulse timing SHALL be unchanged.

Verification
REQ-036 Write test, defaults with CLK_DIV=2: write addr 0x010, data 0x0003 -> 26 sck rising edges; mosi 000010000_1_0000000000000011; ss_n low 108 cycles; no m_valid.
REQ-037 Read test, macro defined: read addr 0x000 with the model driving 0x5031 -> mosi addr 0, bit 0; m_rdata=0x5031; m_valid 1 cycle, CS_GAP-aligned.
REQ-038 Back-to-back test: two writes with s_valid held -> second accepted on first IDLE cycle; ss_n high >=4 cycles between frames; s_ready low throughout the first frame.
REQ-039 Reset test: reset asserted at the 10th sck edge of a read -> ss_n=1 and sck=0 within the same cycle; no m_valid; next command completes normally.
REQ-040 Parameter test: ADDR_BITS=7, DATA_BITS=8, CLK_DIV=1 -> 16-bit frame, sck period 2 cycles; read of 0xA5 returns m_rdata=0xA5.
REQ-041 Macro-undefined test: read of 0x5031 -> m_valid pulses at the same cycle as with the macro; m_rdata=0.
